// File: rtl/msk_and_ghpcll_pipe.sv
// ---------------------------------------------------------------------------
// msk_and_ghpcll_pipe
// W parallel 2-share masked AND lanes built from GHPC low-latency gadgets,
// with valid/ready flow control on data and on fresh randomness.
//
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   in_valid   ina/inb hold a valid transfer
//   in_ready   transfer accepted this cycle when in_valid & rnd_valid
//   ina, inb   2W-bit sharings; share i of lane j at bit i*W+j
//   rnd        4W fresh random bits; lane j uses rnd[4j+3:4j]
//   rnd_valid  rnd is fresh this cycle
//   rnd_ready  rnd consumed this cycle (only together with data)
//   out_valid  out holds a valid result
//   out_ready  consumer accepts out this cycle
//   out        2W-bit sharing of a&b, same layout as ina
//
// Parameters
//   d        number of shares, only 2 is supported
//   W        number of lanes
//   OUT_REG  0: 1-cycle latency, 1: extra output register slot (2 cycles)
// ---------------------------------------------------------------------------
module msk_and_ghpcll_pipe #(
    parameter int unsigned d       = 2,
    parameter int unsigned W       = 8,
    parameter int unsigned OUT_REG = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  ina,
    input  logic [2*W-1:0]  inb,
    input  logic [4*W-1:0]  rnd,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out
);

    localparam int unsigned SW = 2 * W;

    // Only the 2-share gadget exists; any other share count must not elaborate.
    if (d != 2) begin : g_bad_share_count
        $error("msk_and_ghpcll_pipe: only d=2 is supported");
    end

    // Share split per lane
    logic [W-1:0]      a0_c;
    logic [W-1:0]      a1_c;
    logic [W-1:0]      b0_c;
    logic [W-1:0]      b1_c;

    // Gadget front end (one share per cone)
    logic [W-1:0][3:0] fx_c;
    logic [W-1:0][3:0] sel_c;
    logic [W-1:0]      s0_c;

    // Stage-1 state
    logic              v1;
    logic [W-1:0][3:0] r_fx;
    logic [W-1:0][3:0] r_sel;
    logic [W-1:0]      r_s0;
    logic [W-1:0]      s1_c;

    // Handshake
    logic              acc_c;
    logic              st1_free_c;
    logic              in_ready_c;

    assign a0_c = ina[W-1:0];
    assign a1_c = ina[SW-1:W];
    assign b0_c = inb[W-1:0];
    assign b1_c = inb[SW-1:W];

    // fx is a function of share 0 only, sel of share 1 only; the shares meet
    // only after stage-1 registers.
    always_comb begin
        fx_c  = '0;
        sel_c = '0;
        s0_c  = '0;
        for (int j = 0; j < int'(W); j++) begin
            fx_c[j]  = {~a0_c[j] & ~b0_c[j], ~a0_c[j] & b0_c[j],
                         a0_c[j] & ~b0_c[j],  a0_c[j] & b0_c[j]};
            sel_c[j] = { a1_c[j] &  b1_c[j],  a1_c[j] & ~b1_c[j],
                        ~a1_c[j] &  b1_c[j], ~a1_c[j] & ~b1_c[j]};
            s0_c[j]  = ^(rnd[4*j +: 4] & sel_c[j]);
        end
    end

    assign acc_c     = in_valid & rnd_valid & in_ready_c;
    assign in_ready  = in_ready_c;
    assign rnd_ready = acc_c;

    // Stage-1 data registers: load only on accept, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fx  <= '0;
            r_sel <= '0;
            r_s0  <= '0;
        end else if (acc_c) begin
            r_fx  <= fx_c ^ rnd;
            r_sel <= sel_c;
            r_s0  <= s0_c;
        end
    end

    // Stage-1 valid flag; a same-cycle accept wins over the drain
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (acc_c) begin
            v1 <= 1'b1;
        end else if (st1_free_c) begin
            v1 <= 1'b0;
        end
    end

    // share1 XOR tree reads registers only (glitch-robust recombination)
    always_comb begin
        s1_c = '0;
        for (int j = 0; j < int'(W); j++) begin
            s1_c[j] = ^(r_fx[j] & r_sel[j]);
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic          v2;
        logic [SW-1:0] r_out;
        logic          ld2_c;

        // Stage 2 takes the stage-1 result whenever its slot is empty or draining
        assign ld2_c      = v1 & (~v2 | out_ready);
        assign st1_free_c = ld2_c;
        assign in_ready_c = ~v1 | ~v2 | out_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2    <= 1'b0;
                r_out <= '0;
            end else begin
                if (ld2_c) begin
                    v2    <= 1'b1;
                    r_out <= {s1_c, r_s0};
                end else if (out_ready) begin
                    v2    <= 1'b0;
                end
            end
        end

        assign out_valid = v2;
        assign out       = r_out;
    end else begin : g_no_out_reg
        assign st1_free_c = out_ready;
        assign in_ready_c = ~v1 | out_ready;
        assign out_valid  = v1;
        assign out        = {s1_c, r_s0};
    end

endmodule

// File: tb/tb_msk_and_ghpcll_pipe.sv
// ---------------------------------------------------------------------------
// tb_msk_and_ghpcll_pipe
// Drives an OUT_REG=0 and an OUT_REG=1 instance (one active at a time) and
// compares against a transaction-level model: a FIFO of expected results,
// each stamped with its accept cycle.
// ---------------------------------------------------------------------------
module tb_msk_and_ghpcll_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = 2 * W;
    localparam int unsigned RW = 4 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          rnd_valid;
    logic          out_ready;
    logic [SW-1:0] ina;
    logic [SW-1:0] inb;
    logic [RW-1:0] rnd;
    int            mode;

    logic          iv0, rv0, ir0, rr0, ov0;
    logic          iv1, rv1, ir1, rr1, ov1;
    logic [SW-1:0] o0, o1;

    logic          m_ir, m_rr, m_ov;
    logic [SW-1:0] m_out;

    always #5 clk = ~clk;

    assign iv0 = in_valid  && (mode == 0);
    assign rv0 = rnd_valid && (mode == 0);
    assign iv1 = in_valid  && (mode == 1);
    assign rv1 = rnd_valid && (mode == 1);

    assign m_ir  = (mode == 1) ? ir1 : ir0;
    assign m_rr  = (mode == 1) ? rr1 : rr0;
    assign m_ov  = (mode == 1) ? ov1 : ov0;
    assign m_out = (mode == 1) ? o1  : o0;

    msk_and_ghpcll_pipe #(.d(2), .W(W), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv0), .in_ready(ir0), .ina(ina), .inb(inb),
        .rnd(rnd), .rnd_valid(rv0), .rnd_ready(rr0),
        .out_valid(ov0), .out_ready(out_ready), .out(o0)
    );

    msk_and_ghpcll_pipe #(.d(2), .W(W), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .ina(ina), .inb(inb),
        .rnd(rnd), .rnd_valid(rv1), .rnd_ready(rr1),
        .out_valid(ov1), .out_ready(out_ready), .out(o1)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int n_out  = 0;
    logic last_ir;

    logic [W-1:0] exp_and_q[$];
    logic [W-1:0] exp_s0_q[$];
    int           stamp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [W-1:0] unmask(input logic [SW-1:0] s);
        return s[W-1:0] ^ s[SW-1:W];
    endfunction

    // Reference: a&b per lane; share 0 is the random bit picked by (a1,b1)
    function automatic logic [2*W-1:0] ref_result(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                                  input logic [RW-1:0] r);
        logic [W-1:0] res;
        logic [W-1:0] s0;
        logic [RW-1:0] rr;
        int k;
        rr = r;
        for (int j = 0; j < int'(W); j++) begin
            res[j] = (a[j] ^ a[W+j]) & (b[j] ^ b[W+j]);
            k      = 2 * int'(a[W+j]) + int'(b[W+j]);
            s0[j]  = rr[4*j + k];
        end
        return {res, s0};
    endfunction

    task automatic clear_model();
        exp_and_q.delete();
        exp_s0_q.delete();
        stamp_q.delete();
    endtask

    // One cycle: drive at negedge, check, clock, update model
    task automatic step(input logic iv, input logic rv, input logic ordy,
                        input logic [SW-1:0] a, input logic [SW-1:0] b, input logic [RW-1:0] r);
        logic exp_v, exp_ir, acc, drain;
        logic [2*W-1:0] rr;
        int lat;
        in_valid  = iv;
        rnd_valid = rv;
        out_ready = ordy;
        ina = a;
        inb = b;
        rnd = r;
        #1;
        lat    = (mode == 1) ? 2 : 1;
        exp_v  = (exp_and_q.size() > 0) && ((cyc - stamp_q[0]) >= lat - 1);
        exp_ir = (exp_and_q.size() < lat) || ordy;
        last_ir = m_ir;
        check("out_valid", 64'(m_ov), 64'(exp_v));
        check("in_ready", 64'(m_ir), 64'(exp_ir));
        acc = iv && rv && exp_ir;
        check("rnd_ready", 64'(m_rr), 64'(acc));
        if (exp_v) begin
            check("and_value", 64'(unmask(m_out)), 64'(exp_and_q[0]));
            check("share0", 64'(m_out[W-1:0]), 64'(exp_s0_q[0]));
        end
        drain = exp_v && ordy;
        @(posedge clk);
        cyc++;
        if (drain) begin
            void'(exp_and_q.pop_front());
            void'(exp_s0_q.pop_front());
            void'(stamp_q.pop_front());
            n_out++;
        end
        if (acc) begin
            rr = ref_result(a, b, r);
            exp_and_q.push_back(rr[2*W-1:W]);
            exp_s0_q.push_back(rr[W-1:0]);
            stamp_q.push_back(cyc);
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    endtask

    // Reset one cycle (optionally with an acceptable transfer pending) and check both instances
    task automatic do_reset(input logic iv);
        rst       = 1'b1;
        in_valid  = iv;
        rnd_valid = iv;
        out_ready = 1'b0;
        ina = SW'($urandom);
        inb = SW'($urandom);
        rnd = RW'($urandom);
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        clear_model();
        #1;
        check("rst_out_valid0", 64'(ov0), 64'd0);
        check("rst_out0", 64'(o0), 64'd0);
        check("rst_in_ready0", 64'(ir0), 64'd1);
        check("rst_rnd_ready0", 64'(rr0), 64'd0);
        check("rst_out_valid1", 64'(ov1), 64'd0);
        check("rst_out1", 64'(o1), 64'd0);
        check("rst_in_ready1", 64'(ir1), 64'd1);
        check("rst_rnd_ready1", 64'(rr1), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [SW-1:0] a, b;
        logic [RW-1:0] r;
        logic [3:0]    c;
        logic [W-1:0]  s0a, s0b;
        int base_acc, base_out, fall_at;

        mode = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        out_ready = 1'b0;
        ina = '0;
        inb = '0;
        rnd = '0;
        @(negedge clk);
        do_reset(1'b0);

        // All 16 share combinations (8 lanes x 2 transfers) with three rnd patterns
        for (int rep = 0; rep < 3; rep++) begin
            for (int half = 0; half < 2; half++) begin
                for (int j = 0; j < int'(W); j++) begin
                    c = 4'(half * 8 + j);
                    a[j] = c[0]; a[W+j] = c[1];
                    b[j] = c[2]; b[W+j] = c[3];
                end
                r = (rep == 0) ? '0 : (rep == 1) ? '1 : RW'($urandom);
                step(1'b1, 1'b1, 1'b1, a, b, r);
            end
        end
        idle(2);

        // Same sharing, rnd all-zero then all-one: share 0 must flip
        a = {8'hFF, 8'h00};
        step(1'b1, 1'b1, 1'b1, a, a, '0);
        s0a = m_out[W-1:0];
        step(1'b1, 1'b1, 1'b1, a, a, '1);
        s0b = m_out[W-1:0];
        check("mask_share0_differs", 64'(s0a != s0b), 64'd1);
        idle(2);

        // Randomness starvation on both instances
        for (int m = 0; m < 2; m++) begin
            mode = m;
            base_out = n_out;
            a = SW'($urandom);
            b = SW'($urandom);
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, a, b, RW'($urandom));
            check("starve_no_result", 64'(n_out - base_out), 64'd0);
            step(1'b1, 1'b1, 1'b1, a, b, RW'($urandom));
            idle(3);
            check("starve_one_result", 64'(n_out - base_out), 64'd1);
        end

        // Backpressure on OUT_REG=1: 6 transfers, consumer stalled 4 cycles
        mode = 1;
        base_acc = n_acc;
        base_out = n_out;
        fall_at = -1;
        for (int cc = 0; cc < 12; cc++) begin
            step((n_acc - base_acc) < 6, 1'b1, cc >= 4, SW'($urandom), SW'($urandom), RW'($urandom));
            if (!last_ir && fall_at < 0) fall_at = n_acc - base_acc;
            if (cc == 7) check("bp_throughput", 64'(n_acc - base_acc), 64'd6);
        end
        check("bp_stall_after", 64'(fall_at), 64'd2);
        check("bp_results", 64'(n_out - base_out), 64'd6);

        // Reset with both stages full and a transfer offered at the reset edge
        step(1'b1, 1'b1, 1'b0, SW'($urandom), SW'($urandom), RW'($urandom));
        step(1'b1, 1'b1, 1'b0, SW'($urandom), SW'($urandom), RW'($urandom));
        base_out = n_out;
        do_reset(1'b1);
        idle(3);
        check("rst_no_stale", 64'(n_out - base_out), 64'd0);

        // Random traffic on both instances
        for (int m = 0; m < 2; m++) begin
            mode = m;
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                     SW'($urandom), SW'($urandom), RW'($urandom));
            end
            idle(4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
